// File: rtl/sal_ref_ctrl.sv
// sal_ref_ctrl: refresh scheduler with postponed-refresh debt, all-bank and per-bank round-robin modes.
module sal_ref_ctrl #(
  parameter int BK_CNT   = 16,
  parameter int TREFI_W  = 16,
  parameter int TRFC_W   = 10,
  parameter int DEBT_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_ref_en_i,
  input  logic                cfg_pb_mode_i,
  input  logic [TREFI_W-1:0]  cfg_trefi_i,
  input  logic [TRFC_W-1:0]   cfg_trfc_i,
  input  logic [BK_CNT-1:0]   ref_gnt_i,
  output logic [BK_CNT-1:0]   ref_req_o,
  output logic                ref_busy_o,
  output logic                ref_urgent_o,
  output logic [3:0]          ref_debt_o,
  output logic                ref_ovf_o
);
  localparam int PW = BK_CNT > 1 ? $clog2(BK_CNT) : 1;
  typedef enum logic [1:0] {IDLE, REQ, RFC} state_t;
  state_t              r_state, w_next;
  logic [TREFI_W-1:0]  r_icnt, w_icur;
  logic                r_run;
  logic [TRFC_W-1:0]   r_rcnt;
  logic [BK_CNT-1:0]   r_mask;
  logic [PW-1:0]       r_ptr;
  logic                r_pb;
  logic [3:0]          r_debt;
  logic                r_ovf;
  logic                w_active, w_tick, w_go, w_done, w_wrap, w_dec;
  // r_run low means the interval counter behaves as freshly reloaded this cycle
  assign w_active = cfg_ref_en_i && cfg_trefi_i != '0;
  assign w_icur   = r_run ? r_icnt : cfg_trefi_i - TREFI_W'(1);
  assign w_tick   = w_active && w_icur == '0;
  assign w_go     = r_pb ? ref_gnt_i[r_ptr] : &(r_mask | ref_gnt_i);
  assign w_done   = r_state == RFC && r_rcnt == TRFC_W'(1);
  assign w_wrap   = r_ptr == PW'(BK_CNT-1);
  assign w_dec    = w_done && (!r_pb || w_wrap);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // a partially completed per-bank sweep (pointer not at 0) keeps re-entering REQ
  always_comb begin
    w_next = r_state == IDLE ? ((cfg_ref_en_i && (r_debt != '0 || (cfg_pb_mode_i && r_ptr != '0))) ? REQ : IDLE)
           : r_state == REQ  ? (w_go ? RFC : REQ)
           :                   (w_done ? IDLE : RFC);
  end
  always_comb begin
    ref_req_o    = r_state != REQ ? '0 : r_pb ? (BK_CNT'(1) << r_ptr) : ~r_mask;
    ref_busy_o   = r_state != IDLE;
    ref_urgent_o = r_debt >= 4'(DEBT_MAX-1);
    ref_debt_o   = r_debt;
    ref_ovf_o    = r_ovf;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run  <= 1'b0;
      r_icnt <= '0;
      r_mask <= '0;
      r_pb   <= 1'b0;
      r_rcnt <= '0;
      r_ptr  <= '0;
      r_debt <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_run <= w_active;
      if (w_active) r_icnt <= w_tick ? cfg_trefi_i - TREFI_W'(1) : w_icur - TREFI_W'(1);
      r_mask <= (r_state == REQ && !r_pb && !w_go) ? (r_mask | ref_gnt_i) : '0;
      if (r_state == IDLE && w_next == REQ) r_pb <= cfg_pb_mode_i;
      if (r_state == REQ && w_go) r_rcnt <= cfg_trfc_i == '0 ? TRFC_W'(1) : cfg_trfc_i;
      else if (r_state == RFC) r_rcnt <= r_rcnt - TRFC_W'(1);
      if (w_done && r_pb) r_ptr <= w_wrap ? '0 : r_ptr + PW'(1);
      if (w_tick && !w_dec) begin
        if (r_debt == 4'(DEBT_MAX)) r_ovf <= 1'b1;
        else r_debt <= r_debt + 4'd1;
      end else if (w_dec && !w_tick && r_debt != '0) r_debt <= r_debt - 4'd1;
    end
  end
endmodule
